scan_misr_reg: RTL and testbench
================================

# scan_misr_reg

Parametrised scan register for the gate-level test library. It has a functional parallel load, a scan shift path with a WIDTH-cycle shift-complete indication, and a MISR signature-compaction mode for SBST response collection. It replaces the fixed single-bit scan flip-flop with a WIDTH-bit bank that both ATPG flows and software-based self-test flows can use. It sits on data-path observation points, such as the register-file write port and ALU result, where it collects signatures that a test program reads back.

## Interface
- WIDTH, 32: register width in bits; minimum 2.
- POLY, 32'h04C11DB7: MISR feedback polynomial. It is WIDTH bits wide; bit i set means feedback into bit i.
- RESET_VAL, 0: value of Q after reset and after CLR; WIDTH bits.
- CW, 16: width of the compaction counter SIG_CNT.

Ports:
- CK  in  1  clock; all state changes on the rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous clear; highest synchronous priority.
- SE  in  1  scan enable.
- SI  in  1  scan serial input.
- EN  in  1  functional update enable.
- MODE  in  1  0 = parallel load, 1 = MISR compaction.
- D  in  WIDTH  functional data / MISR input word.
- Q  out  WIDTH  register contents.
- SO  out  1  scan serial output, equal to Q[WIDTH-1] (combinational from the register).
- SHIFT_DONE  out  1  registered one-cycle pulse marking WIDTH consecutive shifts.
- SIG_CNT  out  CW  number of MISR compactions since the last reset or CLR; saturates at its maximum.

## Operation
- Reset values while RESETN = 0:
  - Q = RESET_VAL; SO = RESET_VAL[WIDTH-1].
  - SHIFT_DONE = 0, SIG_CNT = 0, internal shift counter = 0.
  - Reset takes effect immediately and overrides everything, including mid-shift and mid-compaction.
- Synchronous priority per rising edge: CLR > SE > EN; if none is active, hold.
- CLR = 1:
  - Q ← RESET_VAL; SIG_CNT ← 0; shift counter ← 0; SHIFT_DONE ← 0.
  - SE, EN and MODE are ignored.
- SE = 1 (CLR = 0), scan shift:
  - Q ← {Q[WIDTH-2:0], SI}.
  - EN and MODE are ignored; SIG_CNT holds.
- EN = 1, MODE = 0: Q ← D.
- EN = 1, MODE = 1, MISR step:
  - Q ← ({Q[WIDTH-2:0],1'b0} ^ (Q[WIDTH-1] ? POLY : 0)) ^ D.
  - SIG_CNT ← SIG_CNT + 1, saturating at 2^CW − 1 (no wrap).
- EN = 0 and SE = 0: all state holds.
- Shift counter (internal, ceil(log2(WIDTH)) bits):
  - Increments on each edge with SE = 1 and CLR = 0.
  - Any edge with SE = 0 resets it to 0.
  - On the edge where it equals WIDTH−1 and SE = 1, it wraps to 0 and SHIFT_DONE ← 1.
  - On every other edge, SHIFT_DONE ← 0.
- Continuous shifting therefore produces SHIFT_DONE every WIDTH cycles.
- A non-contiguous SE pattern never produces SHIFT_DONE until WIDTH back-to-back shifts occur.

## Timing
- Parallel load and MISR step: Q updates on the same edge where EN is sampled, so latency is 1 cycle.
- Scan: the first bit shifted in reaches SO after WIDTH edges.
- SO changes on every shift edge: it shows the old Q[WIDTH-2] after that edge.
- SHIFT_DONE is high for exactly the one cycle following the WIDTHth consecutive shift edge.
- Simultaneous events:
  - SE = 1 with EN = 1: shift wins, with no compaction and no SIG_CNT increment.
  - CLR with SE on the final shift: SHIFT_DONE stays 0.
- Deasserting RESETN is synchronised by the external reset tree. The block requires RESETN to be released away from a CK edge.
- No combinational path from inputs to outputs.

## Test plan
- Reset (WIDTH=8, RESET_VAL=8'h5A):
  - Stimulus: assert RESETN = 0 mid-cycle.
  - Required response: Q = 8'h5A, SO = 0, SHIFT_DONE = 0 and SIG_CNT = 0 immediately, with no CK edge.
- Scan shift (WIDTH=8):
  - Stimulus: from Q = 0, shift SI = 1,0,1,1,0,0,1,0 on 8 consecutive edges.
  - Required response: Q = 8'hB2; SO = 1 after the 8th edge; SHIFT_DONE high for exactly the cycle after edge 8.
  - Continuing 8 more shifts pulses SHIFT_DONE again.
- MISR (WIDTH=8, POLY=8'h1D):
  - Stimulus: Q = 8'h80, D = 0, EN = 1, MODE = 1 → required response: Q = 8'h1D.
  - Next stimulus: D = 8'h3A → required response: Q = 8'h00 (the shifted value 8'h3A XOR D); SIG_CNT = 2.
- Priority:
  - Stimulus: SE = 1, EN = 1, MODE = 1, SI = 1 with Q = 8'h01 → required response: Q = 8'h03; SIG_CNT unchanged.
  - Stimulus: CLR with SE = 1 → required response: Q = RESET_VAL; shift counter cleared.
- Interrupted shift:
  - Stimulus: 5 shifts, then SE = 0 for 1 cycle, then 7 shifts.
  - Required response: no SHIFT_DONE. The 8th shift of the new run pulses SHIFT_DONE.
- Saturation (CW=2):
  - Stimulus: 5 MISR steps → required response: SIG_CNT = 3, stays 3.
  - Stimulus: CLR → required response: SIG_CNT = 0.

Source files
------------

// File: rtl/scan_misr_reg.sv
// WIDTH-bit scan register with parallel load, serial scan shift and MISR compaction.
// Per-edge priority: CLR > SE > EN. SHIFT_DONE pulses after every WIDTH back-to-back shifts.
module scan_misr_reg #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   POLY      = 32'h04C11DB7,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CW        = 16
) (
    input  logic             CK,
    input  logic             RESETN,
    input  logic             CLR,
    input  logic             SE,
    input  logic             SI,
    input  logic             EN,
    input  logic             MODE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             SHIFT_DONE,
    output logic [CW-1:0]    SIG_CNT
);

    localparam int              SCW      = $clog2(WIDTH);
    localparam logic [SCW-1:0]  SC_LAST  = SCW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_MAX  = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    sig_cnt_q, sig_cnt_d;
    logic [SCW-1:0]   shift_cnt_q, shift_cnt_d;
    logic             shift_done_q, shift_done_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        q_d          = q_q;
        sig_cnt_d    = sig_cnt_q;
        shift_cnt_d  = '0;
        shift_done_d = 1'b0;

        if (CLR) begin
            q_d       = RESET_VAL;
            sig_cnt_d = '0;
        end else if (SE) begin
            q_d = {q_q[WIDTH-2:0], SI};
            if (shift_cnt_q == SC_LAST) begin
                shift_done_d = 1'b1;
            end else begin
                shift_cnt_d = shift_cnt_q + SCW'(1);
            end
        end else if (EN) begin
            if (MODE) begin
                q_d = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? POLY : '0) ^ D;
                if (sig_cnt_q != CNT_MAX) begin
                    sig_cnt_d = sig_cnt_q + CW'(1);
                end
            end else begin
                q_d = D;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CK or negedge RESETN) begin
        if (!RESETN) begin
            q_q          <= RESET_VAL;
            sig_cnt_q    <= '0;
            shift_cnt_q  <= '0;
            shift_done_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            sig_cnt_q    <= sig_cnt_d;
            shift_cnt_q  <= shift_cnt_d;
            shift_done_q <= shift_done_d;
        end
    end

    assign Q          = q_q;
    assign SO         = q_q[WIDTH-1];
    assign SHIFT_DONE = shift_done_q;
    assign SIG_CNT    = sig_cnt_q;

endmodule

// File: tb/tb_scan_misr_reg.sv
// Self-checking bench for scan_misr_reg (WIDTH=8, POLY=8'h1D, RESET_VAL=8'h5A, CW=2)
// against a behavioural model that tracks shift run length and compaction count as integers.
module tb_scan_misr_reg;

    localparam logic [7:0] RV   = 8'h5A;
    localparam logic [7:0] POLY = 8'h1D;
    localparam int         CMAX = 3;

    logic       CK = 1'b0;
    logic       RESETN, CLR, SE, SI, EN, MODE;
    logic [7:0] D;
    logic [7:0] Q;
    logic       SO, SHIFT_DONE;
    logic [1:0] SIG_CNT;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_q;
    int         m_cnt;
    int         m_run;
    bit         m_done;

    scan_misr_reg #(.WIDTH(8), .POLY(POLY), .RESET_VAL(RV), .CW(2)) dut (
        .CK(CK), .RESETN(RESETN), .CLR(CLR), .SE(SE), .SI(SI), .EN(EN), .MODE(MODE),
        .D(D), .Q(Q), .SO(SO), .SHIFT_DONE(SHIFT_DONE), .SIG_CNT(SIG_CNT)
    );

    always #5 CK = ~CK;

    // Drives one cycle of inputs, advances the model across the edge, samples 1 time unit later.
    task automatic apply(input bit clr, input bit se, input bit si, input bit en,
                         input bit mode, input logic [7:0] d);
        CLR = clr; SE = se; SI = si; EN = en; MODE = mode; D = d;
        @(posedge CK);
        if (clr) begin
            m_q = RV; m_cnt = 0; m_run = 0; m_done = 0;
        end else if (se) begin
            m_q    = {m_q[6:0], si};
            m_run  = m_run + 1;
            m_done = (m_run % 8) == 0;
        end else begin
            m_run  = 0;
            m_done = 0;
            if (en && mode) begin
                m_q   = ((m_q << 1) & 8'hFF) ^ (m_q >= 8'h80 ? POLY : 8'h00) ^ d;
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end else if (en) begin
                m_q = d;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        CLR = 0; SE = 0; SI = 0; EN = 0; MODE = 0; D = '0;
    endtask

    task automatic test_reset();
        apply(0, 0, 0, 1, 1, 8'hC3);
        for (int i = 0; i < 8; i++) apply(0, 1, i[0], 0, 0, 8'h00);
        #1 RESETN = 1'b0;
        #1;
        checks++;
        if (Q !== RV || SO !== 1'b0 || SHIFT_DONE !== 1'b0 || SIG_CNT !== 2'd0) begin
            failures++;
            $display("FAIL reset_async: Q=%h SO=%b DONE=%b CNT=%0d want Q=%h SO=0 DONE=0 CNT=0",
                     Q, SO, SHIFT_DONE, SIG_CNT, RV);
        end
        SE = 1; SI = 1; EN = 1; D = 8'hFF;
        @(posedge CK); #1;
        checks++;
        if (Q !== RV || SHIFT_DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: Q=%h DONE=%b want Q=%h DONE=0", Q, SHIFT_DONE, RV);
        end
        idle_inputs();
        #3 RESETN = 1'b1;
        m_q = RV; m_cnt = 0; m_run = 0; m_done = 0;
        @(posedge CK); #1;
    endtask

    task automatic test_scan_shift();
        logic [7:0] pat;
        pat = 8'b1011_0010;
        apply(0, 0, 0, 1, 0, 8'h00);
        for (int i = 7; i >= 0; i--) begin
            apply(0, 1, pat[i], 0, 0, 8'h00);
            checks++;
            if (SHIFT_DONE !== (i == 0)) begin
                failures++;
                $display("FAIL scan_done_edge%0d: DONE=%b want %b", 8 - i, SHIFT_DONE, i == 0);
            end
        end
        checks++;
        if (Q !== 8'hB2 || SO !== 1'b1) begin
            failures++;
            $display("FAIL scan_result: Q=%h SO=%b want Q=b2 SO=1", Q, SO);
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 1, 1'($urandom), 0, 0, 8'h00);
            checks++;
            if (SHIFT_DONE !== (i == 7) || Q !== m_q) begin
                failures++;
                $display("FAIL scan_second_run%0d: DONE=%b Q=%h want DONE=%b Q=%h",
                         i, SHIFT_DONE, Q, i == 7, m_q);
            end
        end
    endtask

    task automatic test_misr();
        apply(1, 0, 0, 0, 0, 8'h00);
        apply(0, 0, 0, 1, 0, 8'h80);
        apply(0, 0, 0, 1, 1, 8'h00);
        checks++;
        if (Q !== 8'h1D || SIG_CNT !== 2'd1) begin
            failures++;
            $display("FAIL misr_step1: Q=%h CNT=%0d want Q=1d CNT=1", Q, SIG_CNT);
        end
        apply(0, 0, 0, 1, 1, 8'h3A);
        checks++;
        if (Q !== 8'h00 || SIG_CNT !== 2'd2) begin
            failures++;
            $display("FAIL misr_step2: Q=%h CNT=%0d want Q=00 CNT=2", Q, SIG_CNT);
        end
    endtask

    task automatic test_priority();
        apply(0, 0, 0, 1, 0, 8'h01);
        apply(0, 1, 1, 1, 1, 8'hFF);
        checks++;
        if (Q !== 8'h03 || SIG_CNT !== 2'd2) begin
            failures++;
            $display("FAIL prio_shift_over_misr: Q=%h CNT=%0d want Q=03 CNT=2", Q, SIG_CNT);
        end
        apply(0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) apply(0, 1, 1, 0, 0, 8'h00);
        apply(1, 1, 1, 1, 1, 8'hFF);
        checks++;
        if (Q !== RV || SHIFT_DONE !== 1'b0 || SIG_CNT !== 2'd0) begin
            failures++;
            $display("FAIL prio_clr_over_shift: Q=%h DONE=%b CNT=%0d want Q=%h DONE=0 CNT=0",
                     Q, SHIFT_DONE, SIG_CNT, RV);
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 1, 0, 0, 0, 8'h00);
            checks++;
            if (SHIFT_DONE !== (i == 7)) begin
                failures++;
                $display("FAIL prio_counter_cleared%0d: DONE=%b want %b", i, SHIFT_DONE, i == 7);
            end
        end
    endtask

    task automatic test_interrupted_shift();
        int seen;
        apply(0, 0, 0, 0, 0, 8'h00);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 1, 0, 0, 8'h00);
            seen += int'(SHIFT_DONE);
        end
        apply(0, 0, 0, 0, 0, 8'h00);
        seen += int'(SHIFT_DONE);
        for (int i = 0; i < 7; i++) begin
            apply(0, 1, 0, 0, 0, 8'h00);
            seen += int'(SHIFT_DONE);
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL interrupted_no_done: pulses=%0d want 0", seen);
        end
        apply(0, 1, 0, 0, 0, 8'h00);
        checks++;
        if (SHIFT_DONE !== 1'b1) begin
            failures++;
            $display("FAIL interrupted_eighth: DONE=%b want 1", SHIFT_DONE);
        end
    endtask

    task automatic test_saturation();
        apply(1, 0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            apply(0, 0, 0, 1, 1, 8'($urandom));
            checks++;
            if (SIG_CNT !== 2'((i < CMAX) ? i : CMAX) || Q !== m_q) begin
                failures++;
                $display("FAIL sat_step%0d: CNT=%0d Q=%h want CNT=%0d Q=%h",
                         i, SIG_CNT, Q, (i < CMAX) ? i : CMAX, m_q);
            end
        end
        apply(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (SIG_CNT !== 2'd0) begin
            failures++;
            $display("FAIL sat_clear: CNT=%0d want 0", SIG_CNT);
        end
    endtask

    task automatic test_random();
        bit clr, se;
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 39) == 0);
            se  = ($urandom_range(0, 9) < 7);
            apply(clr, se, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            checks++;
            if (Q !== m_q || SO !== m_q[7] || SHIFT_DONE !== m_done || SIG_CNT !== 2'(m_cnt)) begin
                failures++;
                $display("FAIL random_cycle%0d: Q=%h SO=%b DONE=%b CNT=%0d want Q=%h SO=%b DONE=%b CNT=%0d",
                         i, Q, SO, SHIFT_DONE, SIG_CNT, m_q, m_q[7], m_done, m_cnt);
            end
        end
    endtask

    initial begin
        RESETN = 1'b0;
        idle_inputs();
        m_q = RV; m_cnt = 0; m_run = 0; m_done = 0;
        #12 RESETN = 1'b1;
        @(posedge CK); #1;
        test_reset();
        test_scan_shift();
        test_misr();
        test_priority();
        test_interrupted_shift();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
